// File: rtl/kbd_pkg.sv
// Shared key-event definitions for the keyboard path: event record layout and the
// arbiter's scheduler states.
package kbd_pkg;

  localparam int KEV_W     = 10;
  localparam int KEV_PRESS = 9;
  localparam int KEV_EXT   = 8;

  typedef struct packed {
    logic       press;
    logic       ext;
    logic [7:0] code;
  } kev_t;

  typedef enum logic {
    S_IDLE,
    S_GAPWAIT
  } arb_state_e;

endpackage

// File: rtl/kbd_event_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first full slot after 'last', or slot 0
// outright when PRIO0 is set and slot 0 is full.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter bit PRIO0 = 1'b1
) (
  input  logic [NREQ-1:0]         full_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    any_o = |full_i;
    if (PRIO0 && full_i[0]) begin
      gnt_o[0] = 1'b1;
      found    = 1'b1;
    end
    // k = NREQ wraps back onto 'last' itself, so a lone full slot is still found
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(last_i) + k) % NREQ;
      if (!found && full_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kbd_event_arbiter.sv
// Merges per-source key events onto one paced {strobe, press, code} channel through
// one-entry holding slots and a round-robin scheduler.
module kbd_event_arbiter
  import kbd_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int GAP   = 4,
  parameter bit PRIO0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*KEV_W-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  ev_hold,
  output logic                  ev_strobe,
  output logic                  ev_press,
  output logic [8:0]            ev_code,
  output logic [2:0]            ev_src,
  output logic                  pending
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = $clog2(GAP + 1);

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   gapcnt_q, gapcnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] full_q, full_d;
  kev_t            data_q [NREQ];
  logic            strobe_q, strobe_d;
  logic            press_q, press_d;
  logic [8:0]      code_q, code_d;
  logic [2:0]      src_q, src_d;
  logic            pending_q, pending_d;

  logic [NREQ-1:0] accept;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic            any_full;

  // ready is purely the slot register, so no valid->ready combinational path exists
  assign accept = req_valid & ~full_q;

  rr_pick #(.NREQ(NREQ), .PRIO0(PRIO0)) u_pick (
    .full_i (full_q),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gidx),
    .any_o  (any_full)
  );

  always_comb begin
    state_d  = state_q;
    gapcnt_d = gapcnt_q;
    last_d   = last_q;
    full_d   = full_q | accept;
    strobe_d = 1'b0;
    press_d  = press_q;
    code_d   = code_q;
    src_d    = src_q;
    case (state_q)
      S_IDLE: begin
        if (any_full && !ev_hold) begin
          full_d   = (full_q & ~gnt) | accept;
          strobe_d = 1'b1;
          press_d  = data_q[gidx].press;
          code_d   = {data_q[gidx].ext, data_q[gidx].code};
          src_d    = 3'(gidx);
          last_d   = gidx;
          gapcnt_d = GW'(GAP - 1);
          state_d  = (GAP > 1) ? S_GAPWAIT : S_IDLE;
        end
      end
      S_GAPWAIT: begin
        gapcnt_d = gapcnt_q - 1'b1;
        if (gapcnt_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    pending_d = |full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gapcnt_q  <= '0;
      last_q    <= IW'(NREQ - 1);
      full_q    <= '0;
      strobe_q  <= 1'b0;
      press_q   <= 1'b0;
      code_q    <= '0;
      src_q     <= '0;
      pending_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) data_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      gapcnt_q  <= gapcnt_d;
      last_q    <= last_d;
      full_q    <= full_d;
      strobe_q  <= strobe_d;
      press_q   <= press_d;
      code_q    <= code_d;
      src_q     <= src_d;
      pending_q <= pending_d;
      for (int i = 0; i < NREQ; i++)
        if (accept[i]) data_q[i] <= kev_t'(req_data[i*KEV_W +: KEV_W]);
    end
  end

  assign req_ready = ~full_q;
  assign ev_strobe = strobe_q;
  assign ev_press  = press_q;
  assign ev_code   = code_q;
  assign ev_src    = src_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_kbd_event_arbiter.sv
// Bench: two arbiters (round-robin and PS/2-priority) on shared stimulus, checked
// against a cooldown-based event model, a vector table and directed sequences.
module tb_kbd_event_arbiter;

  localparam int N = 4;
  localparam int G = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*10-1:0] req_data;
  logic            ev_hold;

  logic [N-1:0] rdy [2];
  logic         stb [2];
  logic         prs [2];
  logic [8:0]   code [2];
  logic [2:0]   src [2];
  logic         pend [2];

  kbd_event_arbiter #(.NREQ(N), .GAP(G), .PRIO0(1'b0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy[0]), .ev_hold(ev_hold), .ev_strobe(stb[0]), .ev_press(prs[0]),
    .ev_code(code[0]), .ev_src(src[0]), .pending(pend[0]));

  kbd_event_arbiter #(.NREQ(N), .GAP(G), .PRIO0(1'b1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy[1]), .ev_hold(ev_hold), .ev_strobe(stb[1]), .ev_press(prs[1]),
    .ev_code(code[1]), .ev_src(src[1]), .pending(pend[1]));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a slot table plus "cycles since last grant"; a grant is allowed
  // once that count reaches G, independent of any FSM encoding.
  logic       mf [2][N];
  logic [9:0] md [2][N];
  int         mlast [2];
  int         msince [2];
  logic       mstb [2];
  logic       mprs [2];
  logic [8:0] mcode [2];
  int         msrc [2];

  task automatic model_step();
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        for (int i = 0; i < N; i++) begin mf[p][i] = 1'b0; md[p][i] = '0; end
        mlast[p] = N - 1; msince[p] = G;
        mstb[p] = 1'b0; mprs[p] = 1'b0; mcode[p] = '0; msrc[p] = 0;
      end else begin
        logic fb [N];
        bit   any;
        int   g;
        any = 1'b0; g = -1;
        for (int i = 0; i < N; i++) begin fb[i] = mf[p][i]; any |= fb[i]; end
        if (msince[p] >= G && any && !ev_hold) begin
          if (p == 1 && fb[0]) g = 0;
          else
            for (int k = 1; k <= N; k++)
              if (g < 0 && fb[(mlast[p] + k) % N]) g = (mlast[p] + k) % N;
        end
        mstb[p] = (g >= 0);
        if (g >= 0) begin
          mprs[p] = md[p][g][9]; mcode[p] = md[p][g][8:0]; msrc[p] = g;
          mlast[p] = g; mf[p][g] = 1'b0; msince[p] = 1;
        end else if (msince[p] < G) msince[p]++;
        for (int i = 0; i < N; i++)
          if (req_valid[i] && !fb[i]) begin
            mf[p][i] = 1'b1; md[p][i] = req_data[i*10 +: 10];
          end
      end
    end
  endtask

  task automatic compare_model();
    for (int p = 0; p < 2; p++) begin
      logic [N-1:0] er;
      logic         ep;
      ep = 1'b0;
      for (int i = 0; i < N; i++) begin er[i] = ~mf[p][i]; ep |= mf[p][i]; end
      chk($sformatf("m%0d.strobe", p), stb[p], mstb[p]);
      chk($sformatf("m%0d.press", p), prs[p], mprs[p]);
      chk($sformatf("m%0d.code", p), code[p], mcode[p]);
      chk($sformatf("m%0d.src", p), src[p], msrc[p]);
      chk($sformatf("m%0d.ready", p), rdy[p], er);
      chk($sformatf("m%0d.pending", p), pend[p], ep);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic            rst;
    logic [N-1:0]    vld;
    logic [N*10-1:0] data;
    logic            hold;
    logic            e_stb;
    logic            e_prs;
    logic [8:0]      e_code;
    logic [2:0]      e_src;
    logic [N-1:0]    e_rdy;
    logic            e_pend;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int cnt, last_t, t;
    int srcs [$];
    int times [$];
    bit seen;

    reset = 1'b1; req_valid = '0; req_data = '0; ev_hold = 1'b0;

    // Single event on req 0, then extended break on req 1 (round-robin instance)
    tbl[0] = '{1'b1, 4'b0000, 40'h0,                1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 4'hF, 1'b0};
    tbl[1] = '{1'b0, 4'b0001, 40'h00000_0021C,      1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 4'hE, 1'b1};
    tbl[2] = '{1'b0, 4'b0000, 40'h0,                1'b0, 1'b1, 1'b1, 9'h01C, 3'd0, 4'hF, 1'b0};
    tbl[3] = '{1'b0, 4'b0000, 40'h0,                1'b0, 1'b0, 1'b1, 9'h01C, 3'd0, 4'hF, 1'b0};
    tbl[4] = '{1'b0, 4'b0010, {20'h0, 10'h16B, 10'h0}, 1'b0, 1'b0, 1'b1, 9'h01C, 3'd0, 4'hD, 1'b1};
    tbl[5] = '{1'b0, 4'b0000, 40'h0,                1'b0, 1'b0, 1'b1, 9'h01C, 3'd0, 4'hD, 1'b1};
    tbl[6] = '{1'b0, 4'b0000, 40'h0,                1'b0, 1'b1, 1'b0, 9'h16B, 3'd1, 4'hF, 1'b0};
    tbl[7] = '{1'b0, 4'b0000, 40'h0,                1'b0, 1'b0, 1'b0, 9'h16B, 3'd1, 4'hF, 1'b0};
    for (int r = 0; r < 8; r++) begin
      reset = tbl[r].rst; req_valid = tbl[r].vld; req_data = tbl[r].data; ev_hold = tbl[r].hold;
      tick();
      chk($sformatf("tbl%0d.strobe", r), stb[0], tbl[r].e_stb);
      chk($sformatf("tbl%0d.press", r), prs[0], tbl[r].e_prs);
      chk($sformatf("tbl%0d.code", r), code[0], tbl[r].e_code);
      chk($sformatf("tbl%0d.src", r), src[0], tbl[r].e_src);
      chk($sformatf("tbl%0d.ready", r), rdy[0], tbl[r].e_rdy);
      chk($sformatf("tbl%0d.pending", r), pend[0], tbl[r].e_pend);
    end

    // Fairness: all four loaded together -> 0,1,2,3 spaced G apart
    reset = 1'b1; tick(); reset = 1'b0;
    req_valid = 4'hF; req_data = {10'h225, 10'h226, 10'h21E, 10'h216};
    tick();
    req_valid = '0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (stb[0]) begin srcs.push_back(int'(src[0])); times.push_back(c); end
    end
    chk("fair.count", srcs.size(), 4);
    for (int i = 0; i < 4 && i < srcs.size(); i++) begin
      chk($sformatf("fair.src%0d", i), srcs[i], i);
      chk($sformatf("fair.time%0d", i), times[i], 1 + 4 * i);
    end
    req_valid = 4'hF; tick(); req_valid = '0; tick();
    chk("fair.round2.strobe", stb[0], 1'b1);
    chk("fair.round2.src", src[0], 3'd0);
    repeat (16) tick();

    // Priority: req 0 refilled continuously starves req 2 on the PRIO0 instance
    reset = 1'b1; tick(); reset = 1'b0;
    req_valid = 4'b0101; req_data = {10'h0, 10'h375, 10'h0, 10'h21C};
    tick();
    req_valid = 4'b0001;
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (stb[1]) begin cnt++; chk("prio.src0", src[1], 3'd0); end
    end
    chk("prio.grants_ge3", (cnt >= 3), 1'b1);
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      if (stb[1] && src[1] == 3'd2) begin
        seen = 1'b1;
        chk("prio.req2.code", code[1], 9'h175);
      end
    end
    chk("prio.req2_granted", seen, 1'b1);
    repeat (8) tick();

    // Backpressure: hold for 20 cycles with three slots full
    reset = 1'b1; tick(); reset = 1'b0;
    ev_hold = 1'b1; req_valid = 4'b1011;
    req_data = {10'h211, 10'h0, 10'h212, 10'h213};
    tick();
    req_valid = '0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (stb[0]) cnt++; end
    chk("bp.no_strobe", cnt, 0);
    chk("bp.pending", pend[0], 1'b1);
    chk("bp.ready", rdy[0], 4'b0100);
    ev_hold = 1'b0;
    tick();
    chk("bp.release_strobe", stb[0], 1'b1);
    last_t = 0;
    for (int k = 0; k < 2; k++) begin
      seen = 1'b0;
      for (t = 1; t <= 8 && !seen; t++) begin
        tick();
        if (stb[0]) begin seen = 1'b1; chk($sformatf("bp.gap%0d", k), t, G); end
      end
      chk($sformatf("bp.strobe%0d_seen", k), seen, 1'b1);
    end

    // Reset during the gap with two slots still full
    reset = 1'b1; tick(); reset = 1'b0;
    req_valid = 4'b0111; req_data = {10'h0, 10'h231, 10'h232, 10'h233};
    tick();
    req_valid = '0;
    tick();
    chk("rst.first_strobe", stb[0], 1'b1);
    tick();
    chk("rst.two_full", pend[0], 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst.strobe", stb[0], 1'b0);
    chk("rst.press", prs[0], 1'b0);
    chk("rst.code", code[0], 9'h0);
    chk("rst.src", src[0], 3'd0);
    chk("rst.ready", rdy[0], 4'hF);
    chk("rst.pending", pend[0], 1'b0);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (stb[0] || stb[1]) cnt++; end
    chk("rst.quiet", cnt, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      req_valid = 4'($urandom);
      req_data  = 40'({$urandom(), $urandom()});
      ev_hold   = ($urandom_range(0, 9) < 2);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
